hash_round_ctrl: RTL and testbench
==================================

Name: hash_round_ctrl

Overview:
- Parametrised round/block sequencer for the hash cores. Drives the round index `t` and datapath strobes for one 512-bit block at a time.
- Supports two round counts selected per message: SHA-1 (80 rounds) and SHA-256 (64 rounds).
- Chains multiple blocks of one message with a valid/ready handshake and a `last` flag.
- Sits between the message-schedule/padding front end and the compression datapath; asserts `done` once the final block's chaining update has completed.

Parameters:
- T_W, 8, width of round index `t`; must satisfy 2^T_W >= max(R_SHA1, R_SHA256).
- R_SHA1, 80, rounds per block in mode 0.
- R_SHA256, 64, rounds per block in mode 1.
- BLK_W, 16, width of block counter `blk_cnt`.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  front end offers a block.
- last  in  1  offered block is the final block of its message; sampled on accept.
- mode  in  1  0 = SHA-1, 1 = SHA-256; sampled only on the first block of a message.
- abort  in  1  synchronous cancel of the current message.
- ready  out  1  controller can accept a block (IDLE or WAIT).
- t  out  T_W  current round index.
- load  out  1  one-cycle pulse: datapath loads the working variables.
- first_blk  out  1  qualifies `load`: 1 = load from IV, 0 = load from chaining state.
- round_en  out  1  high on every round cycle.
- update  out  1  one-cycle pulse: add working variables into the chaining state.
- done  out  1  one-cycle pulse: digest is valid.
- busy  out  1  high in LOAD, ROUND, UPDATE, WAIT, DONE.
- mode_q  out  1  latched mode of the message in progress.
- blk_cnt  out  BLK_W  number of blocks accepted in the current/last message.

Behaviour:
- Reset values: state = IDLE, t = 0, blk_cnt = 0, mode_q = 0, last_q = 0, first_q = 0. All outputs are 0 except ready = 1.
- Accept condition: valid && ready. `valid` is ignored while ready = 0, with no buffering.
- Round limit: N = mode_q ? R_SHA256 : R_SHA1.
- State transitions (abort overrides all of them):
  - IDLE: ready = 1. On accept: mode_q <= mode, last_q <= last, first_q <= 1, blk_cnt <= 1, go to LOAD.
  - LOAD (1 cycle): load = 1, first_blk = first_q, t = 0, go to ROUND.
  - ROUND (N cycles): round_en = 1, t steps 0,1,...,N-1. When t == N-1, t holds and the state goes to UPDATE.
  - UPDATE (1 cycle): update = 1, t = N-1. If last_q, go to DONE; else go to WAIT.
  - WAIT: ready = 1, t = 0. On accept: last_q <= last, first_q <= 0, blk_cnt increments (saturating at all-ones), go to LOAD. `mode` is ignored here.
  - DONE (1 cycle): done = 1, t = N-1, go to IDLE.
- `t` timing:
  - t is 0 in IDLE, LOAD and WAIT; it increments only in ROUND and never exceeds N-1.
  - In DONE, t = N-1 (SHA-1: 0x4F, SHA-256: 0x3F).
- Latency: if the accept occurs in cycle k:
  - LOAD in k+1, ROUND in k+2 .. k+N+1, UPDATE in k+N+2.
  - DONE in k+N+3 for a last block; for SHA-1, done is high in k+83.
  - Minimum block-to-block period is N+3 cycles, with valid held high in WAIT.
- abort: when sampled high, the next state is IDLE from any state.
  - t <= 0, blk_cnt <= 0. No update or done pulse follows.
  - abort together with an accept in IDLE: abort wins, and the block is not taken.
- Hold rules:
  - blk_cnt and mode_q hold after DONE until the next first-block accept or an abort.
  - Only one of load, round_en, update, done is high in any cycle.
- Asynchronous reset mid-operation returns to the reset values immediately. No pulses are emitted.
- Illegal state encodings recover to IDLE on the next edge.

Decomposition:
- Package `hash_pkg` holds:
  - the controller state enum (IDLE, LOAD, ROUND, UPDATE, WAIT, DONE);
  - the mode enum (MODE_SHA1 = 0, MODE_SHA256 = 1);
  - default round-count constants, shared with the SHA-1 and SHA-256 datapaths.
- One sub-module, `hash_round_cnt`: a T_W-bit counter with clear, enable and limit inputs that saturates at limit-1 and outputs a `last_round` flag. The FSM stays in `hash_round_ctrl`.

Test Plan:
- Single block, SHA-1: valid = 1, last = 1, mode = 0 in cycle k → load in k+1; t = 0..79 over k+2..k+81; update in k+82; done in k+83 with t = 0x4F; blk_cnt = 1; ready returns high in k+84.
- Single block, SHA-256: mode = 1 → 64 round_en cycles, t peaks at 0x3F, done in k+67.
- Three-block SHA-1 message, valid held high, last on the third block only:
  - first_blk = 1 on the first load only; 3 update pulses and 1 done.
  - Loads are spaced 83 cycles apart; blk_cnt = 3.
- Mode change mid-message: mode toggled to 1 while in WAIT → second block still runs 80 rounds; mode_q stays 0.
- Abort at t = 0x20 of block 2 → IDLE next cycle, t = 0, blk_cnt = 0, no update or done; a fresh message then completes normally.
- Async reset asserted during ROUND, and valid pulsed while busy → outputs return to reset values immediately; valid asserted while busy is never accepted (no extra load).

Source files
------------

// File: rtl/hash_pkg.sv
// Shared definitions for the hash round controller and the SHA-1 / SHA-256 datapaths.
package hash_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ROUND  = 3'd2,
        UPDATE = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
    } ctrl_state_t;

    typedef enum logic {
        MODE_SHA1   = 1'b0,
        MODE_SHA256 = 1'b1
    } hash_mode_t;

    localparam int R_SHA1_DEF   = 80;
    localparam int R_SHA256_DEF = 64;
    localparam int T_W_DEF      = 8;
    localparam int BLK_W_DEF    = 16;

endpackage

// File: rtl/hash_round_cnt.sv
// Round index counter: clears to zero, steps when enabled and saturates at limit-1.
module hash_round_cnt
    import hash_pkg::*;
#(
    parameter int T_W = T_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           en,
    input  logic [T_W-1:0] limit,
    output logic [T_W-1:0] cnt,
    output logic           last_round
);

    logic [T_W-1:0] cnt_r;
    logic [T_W-1:0] lim_m1_s;

    assign lim_m1_s   = limit - {{(T_W-1){1'b0}}, 1'b1};
    assign last_round = (cnt_r == lim_m1_s);
    assign cnt        = cnt_r;

    // Counter register; clear has priority, then a saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {T_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {T_W{1'b0}};
        end else if (en && !last_round) begin
            cnt_r <= cnt_r + {{(T_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/hash_round_ctrl.sv
// Round/block sequencer: walks one 512-bit block through load, rounds and chaining update,
// chaining blocks of a message through a valid/ready handshake.
module hash_round_ctrl
    import hash_pkg::*;
#(
    parameter int T_W      = T_W_DEF,
    parameter int R_SHA1   = R_SHA1_DEF,
    parameter int R_SHA256 = R_SHA256_DEF,
    parameter int BLK_W    = BLK_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             last,
    input  logic             mode,
    input  logic             abort,
    output logic             ready,
    output logic [T_W-1:0]   t,
    output logic             load,
    output logic             first_blk,
    output logic             round_en,
    output logic             update,
    output logic             done,
    output logic             busy,
    output logic             mode_q,
    output logic [BLK_W-1:0] blk_cnt
);

    ctrl_state_t      state_r;
    hash_mode_t       mode_r;
    logic             last_r;
    logic             first_r;
    logic [BLK_W-1:0] blk_cnt_r;
    logic             ready_r;
    logic             load_r;
    logic             first_blk_r;
    logic             round_en_r;
    logic             update_r;
    logic             done_r;
    logic             busy_r;

    logic [T_W-1:0]   limit_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             last_round_s;

    // Round limit and counter control; t is held at zero outside ROUND/UPDATE/DONE.
    always_comb begin
        limit_s   = (mode_r == MODE_SHA256) ? T_W'(R_SHA256) : T_W'(R_SHA1);
        cnt_en_s  = 1'b0;
        cnt_clr_s = 1'b0;
        if (abort) begin
            cnt_clr_s = 1'b1;
        end else begin
            case (state_r)
                ROUND:   cnt_en_s  = 1'b1;
                UPDATE:  cnt_clr_s = !last_r;
                default: cnt_clr_s = 1'b1;
            endcase
        end
    end

    hash_round_cnt #(
        .T_W (T_W)
    ) u_round_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (cnt_clr_s),
        .en         (cnt_en_s),
        .limit      (limit_s),
        .cnt        (t),
        .last_round (last_round_s)
    );

    // Controller FSM with registered strobes; abort overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mode_r      <= MODE_SHA1;
            last_r      <= 1'b0;
            first_r     <= 1'b0;
            blk_cnt_r   <= {BLK_W{1'b0}};
            ready_r     <= 1'b1;
            load_r      <= 1'b0;
            first_blk_r <= 1'b0;
            round_en_r  <= 1'b0;
            update_r    <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            load_r      <= 1'b0;
            first_blk_r <= 1'b0;
            round_en_r  <= 1'b0;
            update_r    <= 1'b0;
            done_r      <= 1'b0;
            if (abort) begin
                state_r   <= IDLE;
                mode_r    <= MODE_SHA1;
                last_r    <= 1'b0;
                first_r   <= 1'b0;
                blk_cnt_r <= {BLK_W{1'b0}};
                ready_r   <= 1'b1;
                busy_r    <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (valid) begin
                            state_r     <= LOAD;
                            mode_r      <= hash_mode_t'(mode);
                            last_r      <= last;
                            first_r     <= 1'b1;
                            blk_cnt_r   <= {{(BLK_W-1){1'b0}}, 1'b1};
                            load_r      <= 1'b1;
                            first_blk_r <= 1'b1;
                            ready_r     <= 1'b0;
                            busy_r      <= 1'b1;
                        end else begin
                            ready_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end
                    LOAD: begin
                        state_r    <= ROUND;
                        round_en_r <= 1'b1;
                    end
                    ROUND: begin
                        if (last_round_s) begin
                            state_r  <= UPDATE;
                            update_r <= 1'b1;
                        end else begin
                            round_en_r <= 1'b1;
                        end
                    end
                    UPDATE: begin
                        if (last_r) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= WAIT;
                            ready_r <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (valid) begin
                            state_r     <= LOAD;
                            last_r      <= last;
                            first_r     <= 1'b0;
                            load_r      <= 1'b1;
                            first_blk_r <= 1'b0;
                            ready_r     <= 1'b0;
                            if (blk_cnt_r != {BLK_W{1'b1}}) begin
                                blk_cnt_r <= blk_cnt_r + {{(BLK_W-1){1'b0}}, 1'b1};
                            end else begin
                                blk_cnt_r <= blk_cnt_r;
                            end
                        end else begin
                            ready_r <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready     = ready_r;
    assign load      = load_r;
    assign first_blk = first_blk_r & first_r;
    assign round_en  = round_en_r;
    assign update    = update_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign mode_q    = (mode_r == MODE_SHA256);
    assign blk_cnt   = blk_cnt_r;

endmodule

// File: tb/tb_hash_round_ctrl.sv
// Self-checking bench for hash_round_ctrl: directed latency scenarios plus random traffic
// compared against a cycle-schedule reference model.
module tb_hash_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        last;
    logic        mode;
    logic        abort;
    logic        ready;
    logic [7:0]  t;
    logic        load;
    logic        first_blk;
    logic        round_en;
    logic        update;
    logic        done;
    logic        busy;
    logic        mode_q;
    logic [15:0] blk_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0]  tr [0:511];
    logic        rdy[0:511];
    logic        bz [0:511];
    logic [15:0] bc [0:511];
    int          load_at[$];
    int          upd_at[$];
    int          done_at[$];
    logic        fb_q[$];
    int          n_round, max_t, t_done, multi_hot, abort_cyc;

    always #5 clk = ~clk;

    hash_round_ctrl dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .last(last), .mode(mode), .abort(abort),
        .ready(ready), .t(t), .load(load), .first_blk(first_blk), .round_en(round_en),
        .update(update), .done(done), .busy(busy), .mode_q(mode_q), .blk_cnt(blk_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs ncyc cycles offering nblk blocks (last on the final one), mode flipped after the
    // first accept, optional abort at round abort_t of block abort_blk; logs what it sees.
    task automatic observe(input logic m0, input int nblk, input int ncyc,
                           input int abort_blk, input int abort_t);
        int acc;
        acc = 0; n_round = 0; max_t = 0; t_done = -1; multi_hot = 0; abort_cyc = -1;
        load_at.delete(); upd_at.delete(); done_at.delete(); fb_q.delete();
        for (int i = 0; i < ncyc; i++) begin
            tr[i] = t; rdy[i] = ready; bz[i] = busy; bc[i] = blk_cnt;
            if (load) begin load_at.push_back(i); fb_q.push_back(first_blk); end
            if (round_en) begin n_round++; if (int'(t) > max_t) max_t = int'(t); end
            if (update) upd_at.push_back(i);
            if (done) begin done_at.push_back(i); t_done = int'(t); end
            if (int'(load) + int'(round_en) + int'(update) + int'(done) > 1) multi_hot++;
            abort = 1'b0;
            if (abort_blk > 0 && abort_cyc < 0 && load_at.size() == abort_blk && round_en
                && int'(t) == abort_t) begin
                abort = 1'b1;
                abort_cyc = i;
            end
            valid = (acc < nblk) && (abort_cyc < 0);
            last  = (acc == nblk - 1);
            mode  = (acc == 0) ? m0 : ~m0;
            if (valid && ready && !abort) acc++;
            tick();
        end
        valid = 1'b0; last = 1'b0; abort = 1'b0; mode = 1'b0;
    endtask

    function automatic int q_at(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; last = 1'b0; mode = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ready, busy, load, first_blk, round_en, update, done, mode_q} !== 8'b1000_0000) begin
            bad++; $display("FAIL reset_flags: got %b want 10000000",
                            {ready, busy, load, first_blk, round_en, update, done, mode_q});
        end
        total++;
        if (t !== 8'h00 || blk_cnt !== 16'h0000) begin
            bad++; $display("FAIL reset_counts: got t=%h blk=%h want 00/0000", t, blk_cnt);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got ready=%b busy=%b want 1/0", ready, busy);
        end
    endtask

    task automatic test_sha1_single();
        observe(1'b0, 1, 90, 0, 0);
        total++;
        if (load_at.size() != 1 || q_at(load_at, 0) != 1 || fb_q[0] !== 1'b1) begin
            bad++; $display("FAIL sha1_load: got n=%0d at=%0d want 1 at 1", load_at.size(), q_at(load_at, 0));
        end
        total++;
        if (n_round != 80 || tr[2] !== 8'd0 || tr[81] !== 8'd79) begin
            bad++; $display("FAIL sha1_rounds: got n=%0d t2=%0d t81=%0d want 80/0/79", n_round, tr[2], tr[81]);
        end
        total++;
        if (q_at(upd_at, 0) != 82 || q_at(done_at, 0) != 83 || done_at.size() != 1) begin
            bad++; $display("FAIL sha1_latency: got upd=%0d done=%0d want 82/83", q_at(upd_at, 0), q_at(done_at, 0));
        end
        total++;
        if (t_done != 8'h4F || bc[85] !== 16'd1) begin
            bad++; $display("FAIL sha1_done_t: got t=%h blk=%0d want 4f/1", t_done, bc[85]);
        end
        total++;
        if (rdy[83] !== 1'b0 || rdy[84] !== 1'b1 || multi_hot != 0) begin
            bad++; $display("FAIL sha1_ready: got r83=%b r84=%b multi=%0d want 0/1/0", rdy[83], rdy[84], multi_hot);
        end
    endtask

    task automatic test_sha256_single();
        observe(1'b1, 1, 75, 0, 0);
        total++;
        if (n_round != 64 || max_t != 8'h3F) begin
            bad++; $display("FAIL sha256_rounds: got n=%0d max_t=%h want 64/3f", n_round, max_t);
        end
        total++;
        if (q_at(done_at, 0) != 67 || t_done != 8'h3F || mode_q !== 1'b1) begin
            bad++; $display("FAIL sha256_done: got at=%0d t=%h mode_q=%b want 67/3f/1", q_at(done_at, 0), t_done, mode_q);
        end
        total++;
        if (rdy[68] !== 1'b1 || bz[68] !== 1'b0 || tr[68] !== 8'd0) begin
            bad++; $display("FAIL sha256_idle: got ready=%b busy=%b t=%0d want 1/0/0", rdy[68], bz[68], tr[68]);
        end
    endtask

    task automatic test_back_to_back();
        observe(1'b0, 3, 260, 0, 0);
        total++;
        if (load_at.size() != 3 || q_at(load_at, 0) != 1 || q_at(load_at, 1) != 84 || q_at(load_at, 2) != 167) begin
            bad++; $display("FAIL b2b_loads: got n=%0d %0d %0d %0d want 3 1 84 167", load_at.size(),
                            q_at(load_at, 0), q_at(load_at, 1), q_at(load_at, 2));
        end
        total++;
        if (fb_q.size() != 3 || fb_q[0] !== 1'b1 || fb_q[1] !== 1'b0 || fb_q[2] !== 1'b0) begin
            bad++; $display("FAIL b2b_first_blk: got n=%0d want 1,0,0", fb_q.size());
        end
        total++;
        if (upd_at.size() != 3 || done_at.size() != 1 || q_at(done_at, 0) != 249) begin
            bad++; $display("FAIL b2b_pulses: got upd=%0d done=%0d at=%0d want 3/1/249",
                            upd_at.size(), done_at.size(), q_at(done_at, 0));
        end
        total++;
        if (n_round != 240 || bc[255] !== 16'd3 || mode_q !== 1'b0) begin
            bad++; $display("FAIL b2b_mode: got rounds=%0d blk=%0d mode_q=%b want 240/3/0", n_round, bc[255], mode_q);
        end
        total++;
        if (rdy[83] !== 1'b1 || tr[83] !== 8'd0 || bz[83] !== 1'b1 || multi_hot != 0) begin
            bad++; $display("FAIL b2b_wait: got ready=%b t=%0d busy=%b multi=%0d want 1/0/1/0",
                            rdy[83], tr[83], bz[83], multi_hot);
        end
    endtask

    task automatic test_abort();
        observe(1'b0, 3, 200, 2, 32);
        total++;
        if (abort_cyc != 117 || rdy[118] !== 1'b1 || bz[118] !== 1'b0 || tr[118] !== 8'd0 || bc[118] !== 16'd0) begin
            bad++; $display("FAIL abort_idle: got at=%0d ready=%b busy=%b t=%0d blk=%0d want 117/1/0/0/0",
                            abort_cyc, rdy[118], bz[118], tr[118], bc[118]);
        end
        total++;
        if (upd_at.size() != 1 || done_at.size() != 0 || load_at.size() != 2) begin
            bad++; $display("FAIL abort_pulses: got upd=%0d done=%0d load=%0d want 1/0/2",
                            upd_at.size(), done_at.size(), load_at.size());
        end
        valid = 1'b1; last = 1'b1; abort = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0; abort = 1'b0;
        total++;
        if (load !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL abort_vs_accept: got load=%b busy=%b ready=%b want 0/0/1", load, busy, ready);
        end
        observe(1'b0, 1, 90, 0, 0);
        total++;
        if (q_at(done_at, 0) != 83 || bc[89] !== 16'd1) begin
            bad++; $display("FAIL abort_recover: got done=%0d blk=%0d want 83/1", q_at(done_at, 0), bc[89]);
        end
    endtask

    task automatic test_async_reset();
        int loads;
        loads = 0;
        valid = 1'b1; last = 1'b1; mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (load) loads++;
            valid = (i >= 8 && i < 13);
        end
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ready, busy, load, round_en, update, done} !== 6'b100000 || t !== 8'd0 || blk_cnt !== 16'd0) begin
            bad++; $display("FAIL async_reset: got flags=%b t=%0d blk=%0d want 100000/0/0",
                            {ready, busy, load, round_en, update, done}, t, blk_cnt);
        end
        total++;
        if (loads != 1) begin
            bad++; $display("FAIL busy_valid_ignored: got loads=%0d want 1", loads);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    // Random traffic against a schedule model: each accepted block's outputs are a fixed
    // function of cycles elapsed since its accept.
    task automatic test_random();
        int m_acc, m_n, d;
        logic m_last, m_first, m_mode, idle;
        logic [15:0] m_cnt;
        logic e_ready, e_busy, e_load, e_fb, e_re, e_up, e_dn;
        logic [7:0] e_t;
        logic [31:0] got, exp_v;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        m_acc = -1; m_n = 80; m_last = 1'b0; m_first = 1'b0; m_mode = 1'b0; m_cnt = 16'd0;
        for (int i = 0; i < 3000; i++) begin
            d = i - m_acc;
            idle = (m_acc < 0) || (m_last && d >= m_n + 4);
            {e_ready, e_busy, e_load, e_fb, e_re, e_up, e_dn} = 7'b0;
            e_t = 8'd0;
            if (idle) begin
                e_ready = 1'b1;
            end else begin
                e_busy = 1'b1;
                if (d == 1) begin
                    e_load = 1'b1; e_fb = m_first;
                end else if (d <= m_n + 1) begin
                    e_re = 1'b1; e_t = 8'(d - 2);
                end else if (d == m_n + 2) begin
                    e_up = 1'b1; e_t = 8'(m_n - 1);
                end else if (m_last) begin
                    e_dn = 1'b1; e_t = 8'(m_n - 1);
                end else begin
                    e_ready = 1'b1;
                end
            end
            got   = {ready, busy, load, first_blk, round_en, update, done, mode_q, t, blk_cnt};
            exp_v = {e_ready, e_busy, e_load, e_fb, e_re, e_up, e_dn, m_mode, e_t, m_cnt};
            total++;
            if (got !== exp_v) begin
                bad++; $display("FAIL random_cycle%0d: got %h want %h", i, got, exp_v);
            end
            valid = ($urandom_range(0, 1) == 1);
            last  = ($urandom_range(0, 2) == 0);
            mode  = 1'($urandom_range(0, 1));
            if (e_ready && valid) begin
                if (idle) begin
                    m_mode = mode; m_cnt = 16'd1; m_first = 1'b1;
                end else begin
                    m_first = 1'b0;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
                m_last = last;
                m_acc  = i;
                m_n    = m_mode ? 64 : 80;
            end
            tick();
        end
        valid = 1'b0; last = 1'b0; mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sha1_single();
        test_sha256_single();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
